// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and stage-action decoding for the inter-stage pipeline registers.
package pipe_stage_reg_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Default payload width: the widest stage slot (ID/EX).
  localparam int unsigned PAYLOAD_W_IDEX = 119;

  typedef enum logic [2:0] {
    ACT_ADVANCE,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_ERROR
  } stage_act_e;

  // Flush beats any stall; up=0/dn=1 is an illegal stall pattern.
  function automatic stage_act_e decode_action(input logic flush,
                                               input logic up,
                                               input logic dn);
    if (flush)                         return ACT_FLUSH;
    if (up == STOP && dn == NO_STOP)   return ACT_BUBBLE;
    if (up == STOP)                    return ACT_HOLD;
    if (dn == STOP)                    return ACT_ERROR;
    return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the bubble and stall performance counters.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: payload/valid/sticky sideband driven by the
// shared stall vector, with flush, protocol-error flag and saturating perf counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned                PAYLOAD_W   = PAYLOAD_W_IDEX,
  parameter logic [PAYLOAD_W-1:0]       NOP_PAYLOAD = '0,
  parameter int unsigned                STICKY_W    = 1,
  parameter int unsigned                STALL_W     = 6,
  parameter int unsigned                STAGE_IDX   = 2,
  parameter int unsigned                CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [STICKY_W-1:0]  in_sticky,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [STICKY_W-1:0]  out_sticky,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 proto_err
);

  logic up;
  logic dn;

  // The last register in the chain has no downstream stall bit.
  if (STAGE_IDX >= STALL_W) begin : g_bad_idx
    $error("pipe_stage_reg: STAGE_IDX must be less than STALL_W");
    assign up = 1'b0;
    assign dn = 1'b0;
  end else if (STAGE_IDX == STALL_W - 1) begin : g_last
    assign up = stall[STAGE_IDX];
    assign dn = 1'b0;
  end else begin : g_mid
    assign up = stall[STAGE_IDX];
    assign dn = stall[STAGE_IDX+1];
  end

  stage_act_e           act;
  logic                 valid_q,     valid_d;
  logic [PAYLOAD_W-1:0] payload_q,   payload_d;
  logic [STICKY_W-1:0]  sticky_q,    sticky_d;
  logic                 proto_err_q, proto_err_d;
  logic                 inc_bubble;
  logic                 inc_stall;

  always_comb begin
    act         = decode_action(flush, up, dn);
    valid_d     = valid_q;
    payload_d   = payload_q;
    sticky_d    = sticky_q;
    proto_err_d = proto_err_q;
    inc_bubble  = 1'b0;
    inc_stall   = 1'b0;
    unique case (act)
      ACT_FLUSH: begin
        valid_d   = 1'b0;
        payload_d = NOP_PAYLOAD;
        sticky_d  = '0;
      end
      ACT_BUBBLE: begin
        valid_d    = 1'b0;
        payload_d  = NOP_PAYLOAD;
        inc_bubble = 1'b1;
      end
      ACT_HOLD: begin
        inc_stall = 1'b1;
      end
      ACT_ERROR: begin
        inc_stall   = 1'b1;
        proto_err_d = 1'b1;
      end
      ACT_ADVANCE: begin
        valid_d   = in_valid;
        sticky_d  = in_sticky;
        payload_d = in_valid ? in_payload : NOP_PAYLOAD;
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      payload_q   <= NOP_PAYLOAD;
      sticky_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      payload_q   <= payload_d;
      sticky_q    <= sticky_d;
      proto_err_q <= proto_err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_bubble),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_stall),
    .count (stall_cnt)
  );

  assign out_valid   = valid_q;
  assign out_payload = payload_q;
  assign out_sticky  = sticky_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: main instance plus a 2-bit-counter and a last-stage instance.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic         in_valid;
  logic [118:0] in_payload;
  logic [0:0]   in_sticky;
  logic [31:0]  in_payload32;

  logic         out_valid,  out_valid2,  out_valid3;
  logic [118:0] out_payload, out_payload2;
  logic [31:0]  out_payload3;
  logic [0:0]   out_sticky, out_sticky2, out_sticky3;
  logic [15:0]  bubble_cnt, stall_cnt;
  logic [1:0]   bubble_cnt2, stall_cnt2;
  logic [3:0]   bubble_cnt3, stall_cnt3;
  logic         proto_err,  proto_err2,  proto_err3;

  int unsigned tests = 0;
  int unsigned fails = 0;

  assign in_payload32 = in_payload[31:0];

  always #5 clk = ~clk;

  pipe_stage_reg #(.STAGE_IDX(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_payload(out_payload), .out_sticky(out_sticky),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt), .proto_err(proto_err)
  );

  pipe_stage_reg #(.STAGE_IDX(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_sticky(in_sticky),
    .out_valid(out_valid2), .out_payload(out_payload2), .out_sticky(out_sticky2),
    .bubble_cnt(bubble_cnt2), .stall_cnt(stall_cnt2), .proto_err(proto_err2)
  );

  pipe_stage_reg #(.PAYLOAD_W(32), .STAGE_IDX(5), .CNT_W(4)) dut_last (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload32), .in_sticky(in_sticky),
    .out_valid(out_valid3), .out_payload(out_payload3), .out_sticky(out_sticky3),
    .bubble_cnt(bubble_cnt3), .stall_cnt(stall_cnt3), .proto_err(proto_err3)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0;
    in_valid = 1'b0; in_payload = '0; in_sticky = '0;
    step(2);
    chk("rst_valid",   out_valid,   0);
    chk("rst_payload", out_payload, 0);
    chk("rst_sticky",  out_sticky,  0);
    chk("rst_bubble",  bubble_cnt,  0);
    chk("rst_stall",   stall_cnt,   0);
    chk("rst_proto",   proto_err,   0);
    rst = 1'b0;

    // Advance
    in_valid = 1'b1; in_payload = 119'h0DEADBEEF; in_sticky = 1'b1;
    step(1);
    chk("adv_payload", out_payload, 128'hDEADBEEF);
    chk("adv_valid",   out_valid,   1);
    chk("adv_sticky",  out_sticky,  1);

    // Bubble: sticky must hold even though upstream sticky drops
    in_payload = 119'hCAFE; in_sticky = 1'b0; stall = 6'b000100;
    step(3);
    chk("bub_valid",   out_valid,   0);
    chk("bub_payload", out_payload, 0);
    chk("bub_sticky",  out_sticky,  1);
    chk("bub_cnt",     bubble_cnt,  3);
    chk("bub_stallc",  stall_cnt,   0);

    // Hold
    stall = '0; in_valid = 1'b1; in_payload = 119'h55AA; in_sticky = 1'b1;
    step(1);
    chk("hold_load", out_payload, 128'h55AA);
    stall = 6'b001100; in_valid = 1'b0; in_payload = 119'h1111; in_sticky = 1'b0;
    step(5);
    chk("hold_payload", out_payload, 128'h55AA);
    chk("hold_valid",   out_valid,   1);
    chk("hold_sticky",  out_sticky,  1);
    chk("hold_cnt",     stall_cnt,   5);
    chk("hold_bubc",    bubble_cnt,  3);
    chk("hold_proto",   proto_err,   0);

    // Flush during hold
    flush = 1'b1;
    step(1);
    chk("fl_valid",   out_valid,   0);
    chk("fl_payload", out_payload, 0);
    chk("fl_sticky",  out_sticky,  0);
    chk("fl_stallc",  stall_cnt,   5);
    chk("fl_bubc",    bubble_cnt,  3);
    flush = 1'b0;

    // Protocol error: downstream stalled, upstream not
    stall = '0; in_valid = 1'b1; in_payload = 119'h2222; in_sticky = 1'b1;
    step(1);
    stall = 6'b001000; in_payload = 119'h7777;
    step(1);
    chk("err_payload", out_payload, 128'h2222);
    chk("err_proto",   proto_err,   1);
    chk("err_stallc",  stall_cnt,   6);
    stall = '0;
    step(1);
    chk("err_adv_payload", out_payload, 128'h7777);
    chk("err_sticky_flag", proto_err,   1);

    // Invalid capture: payload forced to NOP, sticky still follows upstream
    in_valid = 1'b0; in_payload = 119'h12345678; in_sticky = 1'b1;
    step(1);
    chk("inv_payload", out_payload, 0);
    chk("inv_valid",   out_valid,   0);
    chk("inv_sticky",  out_sticky,  1);

    // Asynchronous reset mid-stall
    stall = 6'b000100;
    step(1);
    chk("pre_rst_bubc", bubble_cnt, 4);
    rst = 1'b1;
    #2;
    chk("arst_valid",   out_valid,   0);
    chk("arst_payload", out_payload, 0);
    chk("arst_sticky",  out_sticky,  0);
    chk("arst_bubble",  bubble_cnt,  0);
    chk("arst_stall",   stall_cnt,   0);
    chk("arst_proto",   proto_err,   0);
    chk("arst_bub2",    bubble_cnt2, 0);
    rst = 1'b0;

    // Saturation: five bubbles into a 2-bit counter
    step(5);
    chk("sat_bub16", bubble_cnt,  5);
    chk("sat_bub2",  bubble_cnt2, 3);

    // Last stage in the chain: stall[5] alone is a bubble, never an error
    stall = 6'b100000; in_valid = 1'b1; in_payload = 119'hABCD;
    step(1);
    chk("last_bubc",  bubble_cnt3, 1);
    chk("last_valid", out_valid3,  0);
    chk("last_proto", proto_err3,  0);
    chk("mid_adv",    out_payload, 128'hABCD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
